// File: rtl/sram_line_prefetch_if.sv
// SRAM read-port bundle between the line prefetcher (master) and the SRAM read stage (slave).
`timescale 1ns/1ps
interface sram_line_prefetch_if #(
   parameter int ADDR_W = 20
);
   logic [ADDR_W-1:0] SRAM_ADDR;
   logic              SRAM_OE_N;
   logic              SRAM_WE_N;
   logic [5:0]        Pix_in;

   modport master (
      output SRAM_ADDR,
      output SRAM_OE_N,
      output SRAM_WE_N,
      input  Pix_in
   );

   modport slave (
      input  SRAM_ADDR,
      input  SRAM_OE_N,
      input  SRAM_WE_N,
      output Pix_in
   );
endinterface

// File: rtl/sram_line_prefetch.sv
// Fetches one picture row of palette indices from SRAM into the write bank of a
// ping-pong line buffer while the display side reads the other bank.
//
//   state | meaning
//   IDLE  | waiting for line_req; SRAM output disabled
//   SETUP | row base address computed and registered
//   ISSUE | one SRAM read address per cycle, LINE_W cycles
//   DRAIN | waits READ_LAT cycles for the last reads, then swaps banks
`timescale 1ns/1ps
module sram_line_prefetch #(
   parameter int                IMG_W     = 640,
   parameter int                LINE_W    = 640,
   parameter int                READ_LAT  = 2,
   parameter int                ADDR_W    = 20,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  line_req,
   input  logic [9:0]            line_y,
   sram_line_prefetch_if.master  sram,
   input  logic [9:0]            rd_x,
   output logic [5:0]            rd_pix,
   output logic                  busy,
   output logic                  done,
   output logic                  overrun
);
   localparam int COL_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
   localparam int DRN_W = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, ISSUE, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [9:0]         y_q;
   logic [COL_W-1:0]   col_q;
   logic [DRN_W-1:0]   drn_q;
   logic [READ_LAT-1:0] vld_q;
   logic [COL_W-1:0]   idx_q [READ_LAT];
   logic               disp_q;
   logic               done_q;
   logic               ovr_q;
   logic [5:0]         rd_pix_q;
   logic [5:0]         mem [2][LINE_W];
   logic               accept;
   logic               last_col;
   logic               last_drn;

   assign last_col = (col_q == COL_W'(LINE_W - 1));
   assign last_drn = (drn_q == '0);

   always_ff @(posedge Clk) begin
      if (!Reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (line_req) begin
               accept  = 1'b1;
               state_d = SETUP;
            end
         end
         SETUP:   state_d = ISSUE;
         ISSUE:   if (last_col) state_d = DRAIN;
         DRAIN:   if (last_drn) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         y_q            <= '0;
         col_q          <= '0;
         drn_q          <= '0;
         vld_q          <= '0;
         disp_q         <= 1'b0;
         done_q         <= 1'b0;
         ovr_q          <= 1'b0;
         sram.SRAM_ADDR <= '0;
         sram.SRAM_OE_N <= 1'b1;
      end else begin
         done_q <= 1'b0;
         if (accept) y_q <= line_y;
         if (line_req && state_q != IDLE) ovr_q <= 1'b1;

         // Read-latency pipeline: each issued column travels with its write index.
         vld_q[0] <= (state_q == ISSUE);
         idx_q[0] <= col_q;
         for (int i = 1; i < READ_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            idx_q[i] <= idx_q[i-1];
         end

         case (state_q)
            SETUP: begin
               sram.SRAM_ADDR <= BASE_ADDR + ADDR_W'(y_q) * ADDR_W'(IMG_W);
               sram.SRAM_OE_N <= 1'b0;
               col_q          <= '0;
            end
            ISSUE: begin
               col_q <= col_q + 1'b1;
               if (last_col) drn_q <= DRN_W'(READ_LAT - 1);
               else          sram.SRAM_ADDR <= sram.SRAM_ADDR + 1'b1;
            end
            DRAIN: begin
               drn_q <= drn_q - 1'b1;
               if (last_drn) begin
                  sram.SRAM_OE_N <= 1'b1;
                  disp_q         <= ~disp_q;
                  done_q         <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // The final capture lands on the same edge as the swap, so it still uses the old write bank.
   always_ff @(posedge Clk) begin
      if (Reset_n && vld_q[READ_LAT-1])
         mem[~disp_q][idx_q[READ_LAT-1]] <= sram.Pix_in;
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n)                  rd_pix_q <= '0;
      else if (int'(rd_x) < LINE_W)  rd_pix_q <= mem[disp_q][rd_x];
      else                           rd_pix_q <= '0;
   end

   assign sram.SRAM_WE_N = 1'b1;
   assign rd_pix         = rd_pix_q;
   assign busy           = (state_q != IDLE);
   assign done           = done_q;
   assign overrun        = ovr_q;
endmodule

// File: tb/tb_sram_line_prefetch.sv
// Two prefetchers (base 0 and base 20'hFFF00) driven by identical stimulus and checked each cycle
// against a cycle-count/array model of the line fetch and ping-pong banks.
`timescale 1ns/1ps
module tb_sram_line_prefetch;
   localparam int LINE_W   = 640;
   localparam int IMG_W    = 640;
   localparam int READ_LAT = 2;
   localparam int DONE_C   = LINE_W + 2 + READ_LAT;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       line_req = 1'b0;
   logic [9:0] line_y = '0;
   logic [9:0] rd_x = '0;
   always #5 clk = ~clk;

   sram_line_prefetch_if #(.ADDR_W(20)) sif0 ();
   sram_line_prefetch_if #(.ADDR_W(20)) sif1 ();
   logic [5:0] rd_pix0, rd_pix1;
   logic       busy0, busy1, done0, done1, ovr0, ovr1;

   sram_line_prefetch #(.IMG_W(IMG_W), .LINE_W(LINE_W), .READ_LAT(READ_LAT), .ADDR_W(20),
                        .BASE_ADDR(20'h00000)) u_dut0 (
      .Clk(clk), .Reset_n(rst_n), .line_req(line_req), .line_y(line_y), .sram(sif0),
      .rd_x(rd_x), .rd_pix(rd_pix0), .busy(busy0), .done(done0), .overrun(ovr0));

   sram_line_prefetch #(.IMG_W(IMG_W), .LINE_W(LINE_W), .READ_LAT(READ_LAT), .ADDR_W(20),
                        .BASE_ADDR(20'hFFF00)) u_dut1 (
      .Clk(clk), .Reset_n(rst_n), .line_req(line_req), .line_y(line_y), .sram(sif1),
      .rd_x(rd_x), .rd_pix(rd_pix1), .busy(busy1), .done(done1), .overrun(ovr1));

   // SRAM read stage: data is a function of the address, READ_LAT cycles later.
   bit mix = 1'b0;
   function automatic logic [5:0] sram_data(input logic [19:0] a, input bit m);
      return m ? (a[5:0] ^ a[15:10]) : a[5:0];
   endfunction

   logic [19:0] p0 [READ_LAT];
   logic [19:0] p1 [READ_LAT];
   always @(posedge clk) begin
      p0[0] <= sif0.SRAM_ADDR;
      p1[0] <= sif1.SRAM_ADDR;
      for (int j = 1; j < READ_LAT; j++) begin
         p0[j] <= p0[j-1];
         p1[j] <= p1[j-1];
      end
   end
   assign sif0.Pix_in = sram_data(p0[READ_LAT-1], mix);
   assign sif1.Pix_in = sram_data(p1[READ_LAT-1], mix);

   logic [19:0] a_addr [2];
   logic        a_oen [2], a_wen [2], a_busy [2], a_done [2], a_ovr [2];
   logic [5:0]  a_pix [2];
   assign a_addr[0] = sif0.SRAM_ADDR;  assign a_addr[1] = sif1.SRAM_ADDR;
   assign a_oen[0]  = sif0.SRAM_OE_N;  assign a_oen[1]  = sif1.SRAM_OE_N;
   assign a_wen[0]  = sif0.SRAM_WE_N;  assign a_wen[1]  = sif1.SRAM_WE_N;
   assign a_busy[0] = busy0;           assign a_busy[1] = busy1;
   assign a_done[0] = done0;           assign a_done[1] = done1;
   assign a_ovr[0]  = ovr0;            assign a_ovr[1]  = ovr1;
   assign a_pix[0]  = rd_pix0;         assign a_pix[1]  = rd_pix1;

   int n_tests = 0;
   int n_fail  = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Model: t counts cycles since the accepting edge (0 = idle); the bank under fetch becomes
   // known only once a fetch runs to completion.
   logic [19:0] base [2];
   int          t = 0;
   logic [9:0]  my = '0;
   int          disp = 0;
   bit          known [2];
   logic [5:0]  mm [2][2][LINE_W];
   logic [19:0] e_addr [2];
   logic [5:0]  e_pix [2];
   bit          e_ovr = 1'b0;
   bit          pix_ok = 1'b1;
   logic [19:0] fa;

   initial begin
      base[0] = 20'h00000;  base[1] = 20'hFFF00;
      known[0] = 1'b0;      known[1] = 1'b0;
      e_addr[0] = '0;       e_addr[1] = '0;
      e_pix[0] = '0;        e_pix[1] = '0;
   end

   always @(posedge clk) begin
      pix_ok = (!rst_n) || (int'(rd_x) >= LINE_W) || known[disp];
      for (int i = 0; i < 2; i++)
         e_pix[i] = (!rst_n || int'(rd_x) >= LINE_W) ? 6'd0 : mm[i][disp][rd_x];
      if (!rst_n) begin
         if (t >= 1 && t < DONE_C) known[1-disp] = 1'b0;
         t = 0;  disp = 0;  e_ovr = 1'b0;
         e_addr[0] = '0;  e_addr[1] = '0;
      end else begin
         if (t >= 1 && t < DONE_C) begin
            if (line_req) e_ovr = 1'b1;
            t++;
            if (t == DONE_C) begin
               for (int i = 0; i < 2; i++)
                  for (int x = 0; x < LINE_W; x++) begin
                     fa = base[i] + 20'(my) * 20'(IMG_W) + 20'(x);
                     mm[i][1-disp][x] = sram_data(fa, mix);
                  end
               known[1-disp] = 1'b1;
               disp = 1 - disp;
            end
         end else if (line_req) begin
            t = 1;  my = line_y;
         end else begin
            t = 0;
         end
         if (t >= 2 && t <= LINE_W + 1)
            for (int i = 0; i < 2; i++)
               e_addr[i] = base[i] + 20'(my) * 20'(IMG_W) + 20'(t - 2);
      end
   end

   bit chk_en = 1'b0;
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("addr%0d", i), 32'(a_addr[i]), 32'(e_addr[i]));
            chk($sformatf("oe_n%0d", i), 32'(a_oen[i]), 32'(!(t >= 2 && t < DONE_C)));
            chk($sformatf("we_n%0d", i), 32'(a_wen[i]), 32'd1);
            chk($sformatf("busy%0d", i), 32'(a_busy[i]), 32'(t >= 1 && t < DONE_C));
            chk($sformatf("done%0d", i), 32'(a_done[i]), 32'(t == DONE_C));
            chk($sformatf("overrun%0d", i), 32'(a_ovr[i]), 32'(e_ovr));
            if (pix_ok) chk($sformatf("rd_pix%0d", i), 32'(a_pix[i]), 32'(e_pix[i]));
         end
      end
   end

   bit rand_rdx = 1'b0;
   always begin
      @(posedge clk);
      #2;
      if (rand_rdx) rd_x = 10'($urandom_range(0, 767));
   end

   int cyc = 0;
   task automatic tick();
      @(posedge clk);
      #2;
   endtask
   task automatic start(input logic [9:0] y);
      line_req = 1'b1;  line_y = y;
      tick();
      line_req = 1'b0;
      cyc = 1;
   endtask
   task automatic go_to(input int c);
      while (cyc < c) begin
         tick();
         cyc++;
      end
   endtask

   initial begin
      repeat (3) tick();
      chk_en = 1'b1;
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_addr", 32'(a_addr[0]), 32'd0);
      chk("rst_oe_n", 32'(a_oen[0]), 32'd1);
      chk("rst_pix", 32'(rd_pix0), 32'd0);
      rst_n = 1'b1;
      repeat (20) tick();

      // Row 3, plain address-as-data SRAM
      start(10'd3);
      go_to(2);
      chk("row3_first_addr0", 32'(a_addr[0]), 32'd1920);
      chk("row3_first_addr1", 32'(a_addr[1]), 32'd1664);
      go_to(641);
      chk("row3_last_addr0", 32'(a_addr[0]), 32'd2559);
      go_to(643);
      chk("row3_no_early_done", 32'(done0), 32'd0);
      go_to(644);
      chk("row3_done_644", 32'(done0), 32'd1);
      chk("row3_busy_low", 32'(busy0), 32'd0);
      for (int x = 0; x < LINE_W; x++) begin
         rd_x = 10'(x);
         tick();
         chk("row3_sweep", 32'(rd_pix0), 32'((1920 + x) % 64));
      end
      rd_x = 10'd700;
      tick();
      chk("rdx_700", 32'(rd_pix0), 32'd0);

      // Row 4 with an address-mixing SRAM so rows differ; display reads randomly meanwhile
      mix = 1'b1;
      rand_rdx = 1'b1;
      start(10'd4);
      go_to(DONE_C);
      rand_rdx = 1'b0;
      rd_x = 10'd10;
      tick();
      chk("row4_x10", 32'(rd_pix0), 32'd8);

      // Overrun mid-fetch, then back-to-back request in the done cycle
      rand_rdx = 1'b1;
      start(10'($urandom_range(0, 1023)));
      go_to(100);
      line_req = 1'b1;  line_y = 10'($urandom_range(0, 1023));
      tick();  cyc++;
      line_req = 1'b0;
      chk("overrun_set", 32'(ovr0), 32'd1);
      go_to(643);
      chk("ovr_no_early_done", 32'(done0), 32'd0);
      go_to(644);
      chk("ovr_done_644", 32'(done0), 32'd1);
      start(10'($urandom_range(0, 1023)));
      chk("b2b_busy", 32'(busy0), 32'd1);
      chk("ovr_sticky", 32'(ovr0), 32'd1);
      go_to(DONE_C);
      repeat (3) tick();

      // Reset in ISSUE cycle 300
      start(10'($urandom_range(0, 1023)));
      go_to(302);
      rst_n = 1'b0;
      tick();  cyc++;
      chk("rst_mid_busy", 32'(busy0), 32'd0);
      chk("rst_mid_oe_n", 32'(a_oen[0]), 32'd1);
      chk("rst_mid_ovr", 32'(ovr0), 32'd0);
      rst_n = 1'b1;
      repeat (700) tick();

      // Largest row: base-0 unit stays in range, the FFF00 unit wraps
      start(10'd1023);
      go_to(2);
      chk("y1023_addr0", 32'(a_addr[0]), 32'd654720);
      chk("y1023_addr1", 32'(a_addr[1]), 32'd654464);
      go_to(DONE_C);
      chk("y1023_done", 32'(done0), 32'd1);

      // Random fetches; the first (row 0) wraps mid-line on the FFF00 unit
      for (int n = 0; n < 5; n++) begin
         repeat ($urandom_range(0, 5)) tick();
         start((n == 0) ? 10'd0 : 10'($urandom_range(0, 1023)));
         if ($urandom_range(0, 1) == 1) begin
            go_to($urandom_range(3, 640));
            line_req = 1'b1;  line_y = 10'($urandom_range(0, 1023));
            tick();  cyc++;
            line_req = 1'b0;
         end
         go_to(DONE_C);
         chk("rand_done", 32'(done0), 32'd1);
      end
      repeat (10) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
